seq_game_ctrl: RTL and testbench

Parametrised memory-game sequencer: builds a random colour sequence one entry per round, replays it through the display path, then checks the player's entries against it. It has a configurable colour width, sequence depth and built-in per-entry response timeout, and reports score and high score. It sits between the input sync/encode block, the random source, the external display timer and the LED/sound drivers, and is the next generation of the game controller.

---
 rtl/seq_game_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seq_game_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_game_ctrl.sv
`timescale 1ns/1ps
// Memory-game sequencer: grows a random colour sequence, replays it, then checks the player's echo.
// High-score tracking (HIGH_SCORE register and HS pulse) is built only when SEQ_GAME_HS_EN is defined.
module seq_game_ctrl #(
    parameter int COLOR_W     = 2,
    parameter int DEPTH       = 32,
    parameter int TURN_CYCLES = 1000,
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int TMR_W      = $clog2(TURN_CYCLES + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [COLOR_W-1:0] IN,
    input  logic               IN_VALID,
    input  logic [COLOR_W-1:0] RAND,
    input  logic               START_GAME,
    input  logic               TIMER_PULSE,
    output logic               TIMER_GO,
    output logic [COLOR_W-1:0] OUT,
    output logic               OUT_ENA,
    output logic               WIN,
    output logic               LOSE,
    output logic               HS,
    output logic [CNT_W-1:0]   SCORE,
    output logic [CNT_W-1:0]   HIGH_SCORE
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADD, S_SHOW, S_SHOW_WAIT, S_INPUT, S_HOLD, S_WIN, S_LOSE
    } state_t;

    state_t state, state_nxt;

    logic [COLOR_W-1:0] stack [DEPTH];
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   i;
    logic [TMR_W-1:0]   tmr;
    logic               good;

    logic last, timeout, at_depth, good_now;

    assign last     = (i == cnt);
    assign timeout  = (tmr == '0);
    assign at_depth = (cnt == CNT_W'(DEPTH - 1));
    // IN is only looked at on the INPUT cycle where IN_VALID is first seen; the verdict is held until release.
    assign good_now = (IN == stack[i[IDX_W-1:0]]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (START_GAME) state_nxt = S_START;
            S_START:     if (!START_GAME) state_nxt = S_ADD;
            S_ADD:       state_nxt = S_SHOW;
            S_SHOW:      state_nxt = S_SHOW_WAIT;
            S_SHOW_WAIT: if (TIMER_PULSE) state_nxt = last ? S_INPUT : S_SHOW;
            S_INPUT: begin
                if (timeout)       state_nxt = S_LOSE;
                else if (IN_VALID) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!IN_VALID) begin
                    if (!good)         state_nxt = S_LOSE;
                    else if (!last)    state_nxt = S_INPUT;
                    else if (at_depth) state_nxt = S_WIN;
                    else               state_nxt = S_ADD;
                end
            end
            S_WIN:   state_nxt = S_IDLE;
            S_LOSE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequence storage carries no reset; every entry is written in ADD before it is shown.
    always_ff @(posedge CLK) begin
        if (state == S_ADD) stack[cnt[IDX_W-1:0]] <= RAND;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT      <= '1;
            OUT_ENA  <= 1'b0;
            TIMER_GO <= 1'b0;
            WIN      <= 1'b0;
            LOSE     <= 1'b0;
            SCORE    <= '0;
            cnt      <= '0;
            i        <= '0;
            tmr      <= '0;
            good     <= 1'b0;
        end else begin
            TIMER_GO <= 1'b0;
            WIN      <= 1'b0;
            LOSE     <= 1'b0;
            case (state)
                S_IDLE: begin
                    OUT_ENA <= 1'b0;
                    if (START_GAME) begin
                        SCORE <= '0;
                        cnt   <= '0;
                        i     <= '0;
                    end
                end
                S_ADD: i <= '0;
                S_SHOW: begin
                    OUT      <= stack[i[IDX_W-1:0]];
                    OUT_ENA  <= 1'b1;
                    TIMER_GO <= 1'b1;
                end
                S_SHOW_WAIT: begin
                    if (TIMER_PULSE) begin
                        OUT_ENA <= 1'b0;
                        if (last) begin
                            i   <= '0;
                            tmr <= TURN_LOAD;
                        end else begin
                            i <= i + CNT_W'(1);
                        end
                    end
                end
                S_INPUT: begin
                    if (!timeout) begin
                        tmr <= tmr - TMR_W'(1);
                        if (IN_VALID) good <= good_now;
                    end
                end
                S_HOLD: begin
                    if (!IN_VALID && good) begin
                        if (last) begin
                            SCORE <= cnt + CNT_W'(1);
                            if (!at_depth) cnt <= cnt + CNT_W'(1);
                        end else begin
                            i   <= i + CNT_W'(1);
                            tmr <= TURN_LOAD;
                        end
                    end
                end
                S_WIN:   WIN  <= 1'b1;
                S_LOSE:  LOSE <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SEQ_GAME_HS_EN
    logic [CNT_W-1:0] high_score_q;
    logic             hs_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            high_score_q <= '0;
            hs_q         <= 1'b0;
        end else begin
            hs_q <= 1'b0;
            // A tie with the existing best is not a new record.
            if ((state == S_WIN || state == S_LOSE) && SCORE > high_score_q) begin
                high_score_q <= SCORE;
                hs_q         <= 1'b1;
            end
        end
    end

    assign HIGH_SCORE = high_score_q;
    assign HS         = hs_q;
`else
    assign HIGH_SCORE = '0;
    assign HS         = 1'b0;
`endif

endmodule

// File: tb/tb_seq_game_ctrl.sv
`timescale 1ns/1ps
// Bench for seq_game_ctrl: a scripted table of games plus random games, checked against a game-level model
// (expected display queue, score and best score derived from the game rules).
module tb_seq_game_ctrl;
    localparam int CW    = 2;
    localparam int D     = 4;
    localparam int T     = 20;
    localparam int CNT_W = $clog2(D + 1);
`ifdef SEQ_GAME_HS_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic             CLK, RST_N;
    logic [CW-1:0]    IN, RAND, OUT;
    logic             IN_VALID, START_GAME, TIMER_PULSE, TIMER_GO, OUT_ENA, WIN, LOSE, HS;
    logic [CNT_W-1:0] SCORE, HIGH_SCORE;

    seq_game_ctrl #(.COLOR_W(CW), .DEPTH(D), .TURN_CYCLES(T)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN(IN), .IN_VALID(IN_VALID), .RAND(RAND),
        .START_GAME(START_GAME), .TIMER_PULSE(TIMER_PULSE), .TIMER_GO(TIMER_GO),
        .OUT(OUT), .OUT_ENA(OUT_ENA), .WIN(WIN), .LOSE(LOSE), .HS(HS),
        .SCORE(SCORE), .HIGH_SCORE(HIGH_SCORE)
    );

    // fail_kind: 0 clean win, 1 wrong colour, 2 no press (timeout), 3 press on the expiry cycle,
    // 4 press on the last legal cycle then win, 5 reset while stuck in the replay
    typedef struct {
        logic [7:0] rnd;
        int         fail_round;
        int         fail_kind;
        int         fail_idx;
        int         exp_score;
        bit         exp_win;
        bit         exp_hs;
        int         exp_hi;
    } game_t;

    int            n_cmp = 0, n_err = 0;
    logic [CW-1:0] exp_q[$];
    int            shows_seen = 0, win_cnt = 0, lose_cnt = 0, hs_cnt = 0;
    int            hi_model = 0;
    bit            timer_en = 1'b1;
    game_t         tbl [9];

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out"}, OUT, {CW{1'b1}});
        chk({tag, "_ena"}, OUT_ENA, 0);
        chk({tag, "_go"}, TIMER_GO, 0);
        chk({tag, "_pulses"}, {WIN, LOSE, HS}, 0);
        chk({tag, "_score"}, SCORE, 0);
        chk({tag, "_hi"}, HIGH_SCORE, 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        IN_VALID = 1'b0;
        START_GAME = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        RST_N = 1'b1;
        hi_model = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          prev_go, prev_win, prev_lose, prev_hs;
        logic [CW-1:0] exp_col;
        prev_go = 0; prev_win = 0; prev_lose = 0; prev_hs = 0;
        forever begin
            @(negedge CLK);
            if (TIMER_GO === 1'b1) begin
                shows_seen++;
                chk("show_ena", OUT_ENA, 1);
                chk("go_1cyc", prev_go, 0);
                if (exp_q.size() == 0) begin
                    fail_now("show_unexpected", shows_seen, shows_seen - 1);
                end else begin
                    exp_col = exp_q.pop_front();
                    chk("show_col", OUT, exp_col);
                end
            end
            if (WIN === 1'b1) begin win_cnt++; chk("win_1cyc", prev_win, 0); end
            if (LOSE === 1'b1) begin lose_cnt++; chk("lose_1cyc", prev_lose, 0); end
            if (HS === 1'b1) begin hs_cnt++; chk("hs_1cyc", prev_hs, 0); end
            prev_go = TIMER_GO; prev_win = WIN; prev_lose = LOSE; prev_hs = HS;
        end
    end

    // ---------------- display-timer responder: pulse 3 cycles after each TIMER_GO ----------------
    initial begin
        int pend;
        pend = 0;
        TIMER_PULSE = 1'b0;
        forever begin
            @(negedge CLK);
            if (!timer_en) begin
                TIMER_PULSE = 1'b0;
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                TIMER_PULSE = (pend == 0);
            end else begin
                TIMER_PULSE = 1'b0;
                if (TIMER_GO === 1'b1) pend = 3;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_input(input int target, output bit ok);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (shows_seen == target && OUT_ENA === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("replay_done_wait", shows_seen, target);
    endtask

    task automatic press(input logic [CW-1:0] col, input logic [CW-1:0] nr, input bit last, input bit wrong);
        IN = col;
        IN_VALID = 1'b1;
        tick();
        repeat (2) begin
            tick();
            if (wrong) chk("lose_at_press", LOSE, 0);
        end
        if (last) RAND = nr;
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic finish_game(input game_t g, input int win0, input int lose0, input int hs0);
        chk("pulse_early", {WIN, LOSE}, 0);
        tick();
        chk("win", WIN, g.exp_win);
        chk("lose", LOSE, !g.exp_win);
        chk("score", SCORE, g.exp_score);
        chk("hs", HS, g.exp_hs & HS_EN);
        tick();
        chk("pulse_end", {WIN, LOSE, HS}, 0);
        chk("high_score", HIGH_SCORE, HS_EN ? g.exp_hi : 0);
        chk("win_count", win_cnt - win0, g.exp_win);
        chk("lose_count", lose_cnt - lose0, !g.exp_win);
        chk("hs_count", hs_cnt - hs0, g.exp_hs & HS_EN);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("idle_ena", OUT_ENA, 0);
    endtask

    task automatic stall_and_reset(input int base);
        bit ok;
        int bad;
        ok = 0;
        bad = 0;
        timer_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (shows_seen == base + 1) begin ok = 1; break; end
        end
        if (!ok) fail_now("stall_show_wait", shows_seen, base + 1);
        repeat (15) begin
            tick();
            if (OUT_ENA !== 1'b1 || LOSE !== 1'b0) bad++;
        end
        chk("show_wait_hold", bad, 0);
        #2 RST_N = 1'b0;
        #1 check_reset("async_rst");
        exp_q.delete();
        timer_en = 1'b1;
        tick();
        RST_N = 1'b1;
        hi_model = 0;
    endtask

    task automatic play_game(input game_t g);
        int            win0, lose0, hs0, base, bad;
        logic [CW-1:0] seq[$];
        logic [CW-1:0] nr, col;
        bit            ok, over, do_finish;
        win0 = win_cnt; lose0 = lose_cnt; hs0 = hs_cnt;
        over = 0;
        do_finish = 1;
        START_GAME = 1'b1;
        tick();
        tick();
        RAND = CW'(g.rnd);
        START_GAME = 1'b0;
        tick();
        chk("score_clear", SCORE, 0);
        for (int r = 1; r <= D && !over; r++) begin
            seq.push_back(CW'(g.rnd >> (2 * (r - 1))));
            foreach (seq[k]) exp_q.push_back(seq[k]);
            base = shows_seen;
            if (g.fail_kind == 5 && r == g.fail_round) begin
                stall_and_reset(base);
                over = 1;
                do_finish = 0;
            end else begin
                wait_input(base + r, ok);
                if (!ok) begin
                    do_reset();
                    over = 1;
                    do_finish = 0;
                end
                for (int k = 0; k < r && !over; k++) begin
                    nr  = CW'(g.rnd >> (2 * r));
                    col = seq[k];
                    if (r == g.fail_round && k == g.fail_idx && g.fail_kind != 0) begin
                        case (g.fail_kind)
                            1: begin
                                press(col ^ 2'b10, nr, 0, 1);
                                over = 1;
                            end
                            2: begin
                                bad = 0;
                                repeat (T + 1) begin
                                    tick();
                                    if (OUT_ENA !== 1'b0 || LOSE !== 1'b0) bad++;
                                end
                                chk("timeout_quiet", bad, 0);
                                over = 1;
                            end
                            3: begin
                                repeat (T) tick();
                                IN = col;
                                IN_VALID = 1'b1;
                                tick();
                                IN_VALID = 1'b0;
                                over = 1;
                            end
                            default: begin
                                repeat (T - 1) tick();
                                press(col, nr, k == r - 1, 0);
                            end
                        endcase
                    end else begin
                        press(col, nr, k == r - 1, 0);
                    end
                end
            end
        end
        if (do_finish) finish_game(g, win0, lose0, hs0);
        tick();
    endtask

    // ---------------- main ----------------
    initial begin
        game_t g;
        bool_fail_init: begin end
        RST_N = 1'b0; IN = '0; IN_VALID = 1'b0; RAND = '0; START_GAME = 1'b0;

        tbl[0] = '{8'h36, 4, 1, 2, 3, 1'b0, 1'b1, 3};
        tbl[1] = '{8'hB1, 3, 2, 0, 2, 1'b0, 1'b0, 3};
        tbl[2] = '{8'h36, 0, 0, 0, 4, 1'b1, 1'b1, 4};
        tbl[3] = '{8'h36, 2, 1, 1, 1, 1'b0, 1'b0, 4};
        tbl[4] = '{8'h1B, 1, 2, 0, 0, 1'b0, 1'b0, 4};
        tbl[5] = '{8'hE4, 2, 3, 1, 1, 1'b0, 1'b0, 4};
        tbl[6] = '{8'h4E, 3, 4, 2, 4, 1'b1, 1'b0, 4};
        tbl[7] = '{8'h93, 3, 5, 0, 0, 1'b0, 1'b0, 0};
        tbl[8] = '{8'h27, 2, 1, 0, 1, 1'b0, 1'b1, 1};

        repeat (3) @(posedge CLK);
        #1 check_reset("reset");
        RST_N = 1'b1;
        tick();
        check_reset("post_reset");

        for (int n = 0; n < 9; n++) begin
            play_game(tbl[n]);
            if (tbl[n].fail_kind == 5) hi_model = 0;
            else if (tbl[n].exp_score > hi_model) hi_model = tbl[n].exp_score;
        end

        for (int n = 0; n < 8; n++) begin
            g.rnd        = 8'($urandom);
            g.fail_kind  = $urandom_range(0, 4);
            g.fail_round = $urandom_range(1, D);
            g.fail_idx   = $urandom_range(0, g.fail_round - 1);
            if (g.fail_kind == 0) g.fail_round = 0;
            g.exp_win    = !(g.fail_kind >= 1 && g.fail_kind <= 3);
            g.exp_score  = g.exp_win ? D : g.fail_round - 1;
            g.exp_hs     = (g.exp_score > hi_model);
            g.exp_hi     = g.exp_hs ? g.exp_score : hi_model;
            play_game(g);
            hi_model = g.exp_hi;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
